// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then performs a byte/half/word access on a word-organised array and returns a response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(4 * DEPTH_WORDS);
    localparam int IW = AW - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_unsigned;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_access;
    logic          w_we, w_uns, w_err;
    logic [31:0]   w_addr, w_wdata, w_wlanes, w_word;
    logic [1:0]    w_size;
    logic [3:0]    w_be;
    logic [IW-1:0] w_idx;

    function automatic logic f_is_err(input logic [31:0] addr, input logic [1:0] size);
        f_is_err = (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || (addr[31:AW] != '0);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   f_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   f_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: f_load = word;
        endcase
    endfunction

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_access = 1'b0;
        case (r_state)
            IDLE: if (req_valid) begin
                w_accept = 1'b1;
                if (LATENCY == 1) begin
                    w_next   = RESP;
                    w_access = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: if (r_cnt == 4'd1) begin
                w_next   = RESP;
                w_access = 1'b1;
            end
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, so it must see the live request.
    assign w_we    = (r_state == IDLE) ? req_we       : r_we;
    assign w_addr  = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_wdata = (r_state == IDLE) ? req_wdata    : r_wdata;
    assign w_size  = (r_state == IDLE) ? req_size     : r_size;
    assign w_uns   = (r_state == IDLE) ? req_unsigned : r_unsigned;
    assign w_err   = f_is_err(w_addr, w_size);
    assign w_idx   = w_addr[AW-1:2];
    assign w_word  = r_mem[w_idx];

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_be     = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_cnt <= CNT_INIT;
            else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
            if (w_access) begin
                r_rdata <= (w_we || w_err) ? 32'h0 : f_load(w_word, w_addr[1:0], w_size, w_uns);
                r_err   <= w_err;
            end else if (r_state == RESP && rsp_ready) begin
                r_rdata <= 32'h0;
                r_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

    // Array contents survive reset; only the write enable depends on the FSM.
    always_ff @(posedge clk) begin
        if (w_access && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (LATENCY 1, 2, 15) share one request stream
// and are compared every cycle against a byte-array model with per-build response timing.
module tb_data_mem_responder;
    localparam int DW = 256;

    logic        clk, rst, req_valid, req_we, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [2:0]  rdy, vld, eo;
    logic [31:0] rd0, rd1, rd2;

    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(eo[0]));
    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(eo[1]));
    data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(eo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mm [3][4*DW];
    bit   [2:0]  pend = 3'b000;
    int          acc [3];
    int          due [3];
    logic [31:0] exp_rd [3];
    logic        exp_err [3];
    logic [31:0] last_rd [3];
    logic        last_err [3];
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;
    logic        c_busy, c_ev;
    logic [31:0] c_rd;

    function automatic int lat(int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 15);
    endfunction

    function automatic logic [31:0] rdsel(int d);
        return (d == 0) ? rd0 : ((d == 1) ? rd1 : rd2);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", nm, act, req, $time);
        end
    endtask

    // Byte-addressed little-endian model of one build's memory and response.
    task automatic model(int d, logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                         logic un, logic commit);
        logic e;
        int n;
        logic [31:0] v;
        e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || (a >= 32'(4 * DW));
        n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        v = 32'h0;
        if (!e) begin
            if (we) begin
                if (commit) for (int i = 0; i < n; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][int'(a) + i];
                if (n < 4 && !un && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            end
        end
        exp_rd[d]  = v;
        exp_err[d] = e;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            for (int d = 0; d < 3; d++) begin
                c_busy = pend[d] && (cyc > acc[d]);
                c_ev   = pend[d] && (cyc >= due[d]);
                c_rd   = rdsel(d);
                chk($sformatf("req_ready_L%0d", lat(d)), 32'(rdy[d]), 32'(!c_busy));
                chk($sformatf("rsp_valid_L%0d", lat(d)), 32'(vld[d]), 32'(c_ev));
                if (c_ev) begin
                    chk($sformatf("rsp_rdata_L%0d", lat(d)), c_rd, exp_rd[d]);
                    chk($sformatf("rsp_err_L%0d", lat(d)), 32'(eo[d]), 32'(exp_err[d]));
                    if (rsp_ready) begin
                        pend[d]     = 1'b0;
                        last_rd[d]  = c_rd;
                        last_err[d] = eo[d];
                    end
                end
            end
        end
    end

    task automatic start(logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic un,
                         logic [2:0] commit);
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
        req_valid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            model(d, we, a, wd, sz, un, commit[d]);
            pend[d] = 1'b1;
            acc[d]  = cyc;
            due[d]  = cyc + lat(d);
        end
    endtask

    task automatic drop_req;
        @(posedge clk); #2;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
    endtask

    task automatic wait_idle(bit rnd);
        int n;
        bit all_busy;
        n = 0;
        while (pend != 3'b000 && n < 100) begin
            all_busy = 1'b1;
            for (int d = 0; d < 3; d++) if (!(pend[d] && cyc > acc[d])) all_busy = 1'b0;
            if (rnd) begin
                rsp_ready = (n > 50) ? 1'b1 : 1'($urandom);
                req_valid = all_busy && 1'($urandom);
                req_addr  = $urandom;
                req_we    = 1'($urandom);
            end
            if (!all_busy) req_valid = 1'b0;
            @(posedge clk); #2;
            n++;
        end
        req_valid = 1'b0;
        if (pend != 3'b000) begin
            checks++; errors++;
            $display("FAIL response_timeout pend=%b t=%0t", pend, $time);
            pend = 3'b000;
        end
    endtask

    task automatic txn(logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic un, bit rnd);
        start(we, a, wd, sz, un, 3'b111);
        drop_req();
        wait_idle(rnd);
    endtask

    task automatic lit(string nm, logic [31:0] v, logic e);
        chk({nm, "_dut"}, last_rd[1], v);
        chk({nm, "_model"}, exp_rd[1], v);
        chk({nm, "_err"}, 32'(last_err[1]), 32'(e));
    endtask

    task automatic chk_reset_outputs(string nm);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_ready_L%0d", nm, lat(d)), 32'(rdy[d]), 32'd1);
            chk($sformatf("%s_valid_L%0d", nm, lat(d)), 32'(vld[d]), 32'd0);
            chk($sformatf("%s_rdata_L%0d", nm, lat(d)), rdsel(d), 32'd0);
            chk($sformatf("%s_err_L%0d", nm, lat(d)), 32'(eo[d]), 32'd0);
        end
    endtask

    initial begin
        int r;
        logic [1:0] sz;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b1;
        #3;
        chk_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #2;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
        lit("store_word", 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        lit("load_word", 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h12, 32'h00000055, 2'b00, 1'b0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        lit("byte_merge", 32'hDE55BEEF, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
        lit("byte_signed", 32'hFFFFFFDE, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0);
        lit("byte_unsigned", 32'h000000DE, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 1'b0);
        lit("half_signed", 32'hFFFFBEEF, 1'b0);
        txn(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 1'b0);
        lit("word_misaligned", 32'h0, 1'b1);
        txn(1'b1, 32'h13, 32'h1234, 2'b01, 1'b0, 1'b0);
        lit("half_store_misaligned", 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        lit("after_bad_store", 32'hDE55BEEF, 1'b0);
        txn(1'b0, 32'(4 * DW), 32'h0, 2'b10, 1'b0, 1'b0);
        lit("out_of_range", 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b0);
        lit("size_11", 32'h0, 1'b1);

        // Back-pressure: every build sits in its response phase with a request knocking.
        rsp_ready = 1'b0;
        start(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 3'b111);
        drop_req();
        repeat (14) begin @(posedge clk); #2; end
        repeat (5) begin
            req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_size = 2'b10;
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(1'b0);
        lit("backpressure", 32'hDE55BEEF, 1'b0);

        // Reset while the LATENCY=2 build waits: only the LATENCY=1 build has already written.
        txn(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0);
        start(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 3'b001);
        drop_req();
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        pend = 3'b000;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0);
        lit("reset_discard", 32'hCAFEF00D, 1'b0);
        chk("reset_kept_L1_model", exp_rd[0], 32'h12345678);
        chk("reset_kept_L1_dut", last_rd[0], 32'h12345678);
        chk("reset_discard_L15_dut", last_rd[2], 32'hCAFEF00D);

        for (int w = 0; w < 16; w++) txn(1'b1, 32'(4 * w), $urandom, 2'b10, 1'b0, 1'b0);
        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11));
            r  = $urandom_range(0, 19);
            a  = (r < 18) ? 32'($urandom_range(0, 63))
               : ((r == 18) ? 32'(4 * DW + $urandom_range(0, 7)) : $urandom);
            txn(1'($urandom), a, $urandom, sz, 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder serving the load/store requests the pipeline's memory stage initiates. It accepts one request at a time over a valid/ready request channel and holds it for a programmable number of wait cycles. It then performs a byte/half/word access on an internal word-organised array and returns the result on a valid/ready response channel. It is the slave end of the processor's data-memory interface and lets the core be exercised against a multi-cycle memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; must be a power of two, 16..4096.
- LATENCY, 2: cycles from request acceptance to first cycle of rsp_valid; legal range 1..15.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  input  2  00 byte, 01 half, 10 word; 11 is an error.
- req_unsigned  input  1  loads only: 1 zero-extends, 0 sign-extends.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator consumes response.
- rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, out of range or had size 11.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid && req_ready, latch we/addr/wdata/size/unsigned.
  - If LATENCY=1, go to RESP.
  - If LATENCY>1, go to WAIT with cnt=LATENCY-1.
- WAIT: req_ready=0. cnt decrements each cycle. When cnt=1, the next edge performs the access and enters RESP.
- Access on the edge entering RESP:
  - Loads capture rsp_rdata and rsp_err.
  - Stores write the array and set rsp_rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready, then the FSM goes to IDLE. No new request is accepted in the same cycle as the response handshake.
- Error check, evaluated on the latched request:
  - size 11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - addr >= 4*DEPTH_WORDS is an error.
  - An error sets rsp_err=1 and rsp_rdata=0, and the array is not modified.
- Word index = addr[log2(4*DEPTH_WORDS)-1:2]. Byte lane = addr[1:0].
- Stores, little-endian:
  - Byte store writes wdata[7:0] to lane addr[1:0].
  - Half store writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all lanes.
  - Unaddressed lanes keep their value.
- Loads extract the same lanes, then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- Request inputs are sampled only at acceptance. Changes after acceptance have no effect.
- The array is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, cnt 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- Acceptance in cycle c0 means rsp_valid rises in cycle c0+LATENCY.
- If rsp_ready=1 in that cycle, req_ready is high again in c0+LATENCY+1.
- Peak throughput is one transaction per LATENCY+1 cycles.
- rsp_ready back-pressure stretches RESP indefinitely, with outputs held bit-stable.
- rst asserted mid-transaction:
  - Returns immediately to IDLE and clears outputs.
  - A store whose write edge has not occurred is discarded.
  - A store already written stays written.
- rsp_ready while rsp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; no queueing.
- A store followed by a load to the same address returns the stored value, since the write completes before the load is accepted.

## Test plan
- LATENCY=2. Store word 0xDEADBEEF at 0x10, then load word 0x10 with rsp_ready=1.
  - Each rsp_valid appears 2 cycles after acceptance.
  - Store response has rdata=0, err=0.
  - Load response has rdata=0xDEADBEEF, err=0.
  - req_ready is high in the cycle after each handshake.
- Byte and half lanes, after word 0x10 = 0xDEADBEEF:
  - Store byte 0x55 at 0x12, then load word 0x10: rdata=0xDE55BEEF.
  - Load byte signed at 0x13: rdata=0xFFFFFFDE.
  - Load byte unsigned at 0x13: rdata=0x000000DE.
  - Load half signed at 0x10: rdata=0xFFFFBEEF.
- Errors:
  - Word load at 0x11: err=1, rdata=0.
  - Half store 0x1234 at 0x13: err=1, and a subsequent word load at 0x10 is unchanged.
  - Load at 4*DEPTH_WORDS: err=1.
  - size=11 gives err=1.
- Back-pressure: hold rsp_ready=0 for 5 cycles on a load of 0x10.
  - rsp_valid, rdata and err are stable throughout.
  - req_ready=0 and a concurrent req_valid is not accepted.
  - Raising rsp_ready completes the handshake, with req_ready=1 the next cycle.
- Reset mid-operation: assert rst in the WAIT cycle of a word store of 0x12345678 to 0x20, where 0x20 was previously 0xCAFEF00D.
  - Outputs return to reset values asynchronously.
  - A later load of 0x20 returns 0xCAFEF00D.
- LATENCY=1 and LATENCY=15 builds: load response arrives exactly 1 and 15 cycles after acceptance respectively.
